collision_detect: RTL and testbench

- Game-state controller and collision checker; the consumer of the tube positions produced by the tube generator, and the producer of the game_end it consumes.
- Each round, snapshots the bird and the three tube positions, then checks one tube per cycle against the bird box and checks the ground.
- Confirms a crash, freezes the game via game_end, and handles restart with a holdoff and a one-cycle new_game pulse.
- Sits between the tube generator, the bird physics block and the top-level button/VGA logic.

---
 rtl/flappy_pkg.sv | 40 ++++
 rtl/tube_hit_check.sv | 51 +++++
 rtl/collision_detect.sv | 204 ++++++++++++++++++++
 tb/tb_collision_detect.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// ----------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the flappy game blocks: the collision/game-state FSM
// encoding, the crash cause codes and the default playfield geometry that the
// draw, tube generator and collision blocks must all agree on.
// No ports; imported with "import flappy_pkg::*;".
// ----------------------------------------------------------------------------
package flappy_pkg;

    // Game-state controller states; SNAP..T2 form one 4-cycle checking round
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNAP  = 3'd1,
        ST_T0    = 3'd2,
        ST_T1    = 3'd3,
        ST_T2    = 3'd4,
        ST_CRASH = 3'd5
    } state_t;

    // Crash cause codes reported on crash_cause
    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_TUBE   = 2'd1;
    localparam logic [1:0] CAUSE_GROUND = 2'd2;

    // Default playfield geometry in pixels
    localparam int DEF_BIRD_X       = 200;
    localparam int DEF_BIRD_SIZE    = 20;
    localparam int DEF_TUBE_W       = 60;
    localparam int DEF_GAP_HALF     = 60;
    localparam int DEF_GROUND_Y     = 440;
    localparam int DEF_HIT_CONFIRM  = 1;
    localparam int DEF_RESTART_HOLD = 20;

    // Zero-extend a 10-bit screen coordinate to the 11-bit compare width so
    // that coordinate + offset sums can never wrap.
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/tube_hit_check.sv
// ----------------------------------------------------------------------------
// tube_hit_check
// Combinational test of the bird box against a single tube.
// A tube occupies columns [tube_x-TUBE_W, tube_x-1] and is solid outside the
// open rows [tube_y-GAP_HALF, tube_y+GAP_HALF-1].
// Ports:
//   bird_y  in  10  top row of the bird box
//   tube_x  in  10  right-edge column of the tube
//   tube_y  in  10  gap centre row of the tube
//   hit     out 1   bird box overlaps solid tube pixels
// ----------------------------------------------------------------------------
module tube_hit_check
    import flappy_pkg::*;
#(
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int TUBE_W    = DEF_TUBE_W,
    parameter int GAP_HALF  = DEF_GAP_HALF
) (
    input  logic [9:0] bird_y,
    input  logic [9:0] tube_x,
    input  logic [9:0] tube_y,
    output logic       hit
);

    localparam logic [10:0] X_LO = 11'(BIRD_X);
    localparam logic [10:0] X_HI = 11'(BIRD_X + BIRD_SIZE + TUBE_W);
    localparam logic [10:0] GAP  = 11'(GAP_HALF);
    localparam logic [10:0] SIZE = 11'(BIRD_SIZE);

    logic [10:0] by;
    logic [10:0] tx;
    logic [10:0] ty;
    logic        x_overlap;
    logic        above_gap;
    logic        below_gap;

    assign by = ext11(bird_y);
    assign tx = ext11(tube_x);
    assign ty = ext11(tube_y);

    // Every bound is rearranged so that only additions appear; the left side
    // of each inequality carries the offset instead of subtracting it from
    // the tube coordinate, which keeps small coordinates from underflowing.
    assign x_overlap = (X_LO < tx) && (X_HI > tx);
    assign above_gap = (by + GAP) < ty;
    assign below_gap = (by + SIZE) > (ty + GAP);

    assign hit = x_overlap && (above_gap || below_gap);

endmodule

// File: rtl/collision_detect.sv
// ----------------------------------------------------------------------------
// collision_detect
// Game-state controller and collision checker. Each round snapshots the bird
// and the three tubes, checks one tube per cycle plus the ground, and after
// enough consecutive hit rounds freezes the game in CRASH. A restart request
// is honoured after a holdoff and produces a one-cycle new_game pulse.
// Ports:
//   clk10        in  1   game tick clock
//   clr          in  1   synchronous active-high reset
//   start        in  1   start/restart button level
//   bird_y_pos   in  10  top row of the bird box
//   tubeN_x_pos  in  10  tube right-edge columns (N = 1..3)
//   tubeN_y_pos  in  10  tube gap centres (N = 1..3)
//   playing      out 1   high in SNAP/T0/T1/T2
//   game_end     out 1   high in CRASH
//   new_game     out 1   one-cycle pulse on restart
//   crash_cause  out 2   CAUSE_NONE / CAUSE_TUBE / CAUSE_GROUND, held in CRASH
//   crash_tube   out 2   index 0..2 of the offending tube, 0 otherwise
// ----------------------------------------------------------------------------
module collision_detect
    import flappy_pkg::*;
#(
    parameter int BIRD_X       = DEF_BIRD_X,
    parameter int BIRD_SIZE    = DEF_BIRD_SIZE,
    parameter int TUBE_W       = DEF_TUBE_W,
    parameter int GAP_HALF     = DEF_GAP_HALF,
    parameter int GROUND_Y     = DEF_GROUND_Y,
    parameter int HIT_CONFIRM  = DEF_HIT_CONFIRM,
    parameter int RESTART_HOLD = DEF_RESTART_HOLD
) (
    input  logic       clk10,
    input  logic       clr,
    input  logic       start,
    input  logic [9:0] bird_y_pos,
    input  logic [9:0] tube1_x_pos,
    input  logic [9:0] tube2_x_pos,
    input  logic [9:0] tube3_x_pos,
    input  logic [9:0] tube1_y_pos,
    input  logic [9:0] tube2_y_pos,
    input  logic [9:0] tube3_y_pos,
    output logic       playing,
    output logic       game_end,
    output logic       new_game,
    output logic [1:0] crash_cause,
    output logic [1:0] crash_tube
);

    state_t      state_q;
    logic [9:0]  snap_by_q;
    logic [9:0]  snap_tx_q [3];
    logic [9:0]  snap_ty_q [3];
    logic        ground_q;
    logic        any_hit_q;
    logic [1:0]  first_tube_q;
    logic [2:0]  hit_cnt_q;
    logic [2:0]  hit_cnt_d;
    logic [7:0]  hold_q;
    logic [7:0]  hold_d;
    logic        new_game_q;
    logic [1:0]  cause_q;
    logic [1:0]  tube_q;

    logic [1:0]  tube_idx;
    logic [9:0]  sel_tx;
    logic [9:0]  sel_ty;
    logic        tube_hit;
    logic        ground_now;
    logic        round_hit;
    logic        confirm;
    logic        hold_done;

    // The state selects which snapshot tube the single checker sees this
    // cycle; outside T1/T2 the mux rests on tube 0, which is what T0 needs.
    always_comb begin
        tube_idx = 2'd0;
        case (state_q)
            ST_T1:   tube_idx = 2'd1;
            ST_T2:   tube_idx = 2'd2;
            default: tube_idx = 2'd0;
        endcase
        sel_tx = snap_tx_q[tube_idx];
        sel_ty = snap_ty_q[tube_idx];
    end

    tube_hit_check #(
        .BIRD_X    (BIRD_X),
        .BIRD_SIZE (BIRD_SIZE),
        .TUBE_W    (TUBE_W),
        .GAP_HALF  (GAP_HALF)
    ) u_tube_hit_check (
        .bird_y (snap_by_q),
        .tube_x (sel_tx),
        .tube_y (sel_ty),
        .hit    (tube_hit)
    );

    // Ground is judged on the live bird position in SNAP, the same value
    // that is being captured into the snapshot at that edge.
    assign ground_now = (ext11(bird_y_pos) + 11'(BIRD_SIZE)) > 11'(GROUND_Y);

    // End-of-round bookkeeping: the T2 tube result is still combinational,
    // so it is folded in here alongside the registered ground/tube flags.
    // The confirm compare is one bit wider so counter+1 cannot wrap.
    always_comb begin
        round_hit = ground_q || any_hit_q || tube_hit;
        hit_cnt_d = (hit_cnt_q == 3'd7) ? hit_cnt_q : hit_cnt_q + 3'd1;
        confirm   = (({1'b0, hit_cnt_q} + 4'd1) == 4'(HIT_CONFIRM));
        hold_d    = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        hold_done = (hold_q >= 8'(RESTART_HOLD));
    end

    // Main controller. The holdoff counter starts at 0 in the first CRASH
    // cycle and start is only honoured once it has reached RESTART_HOLD, so
    // a held start leaves CRASH on the edge closing that cycle. clr sits
    // ahead of everything so a simultaneous start can never pulse new_game.
    always_ff @(posedge clk10) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            snap_by_q    <= '0;
            snap_tx_q[0] <= '0;
            snap_tx_q[1] <= '0;
            snap_tx_q[2] <= '0;
            snap_ty_q[0] <= '0;
            snap_ty_q[1] <= '0;
            snap_ty_q[2] <= '0;
            ground_q     <= 1'b0;
            any_hit_q    <= 1'b0;
            first_tube_q <= 2'd0;
            hit_cnt_q    <= 3'd0;
            hold_q       <= 8'd0;
            new_game_q   <= 1'b0;
            cause_q      <= CAUSE_NONE;
            tube_q       <= 2'd0;
        end else begin
            new_game_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    snap_by_q    <= bird_y_pos;
                    snap_tx_q[0] <= tube1_x_pos;
                    snap_tx_q[1] <= tube2_x_pos;
                    snap_tx_q[2] <= tube3_x_pos;
                    snap_ty_q[0] <= tube1_y_pos;
                    snap_ty_q[1] <= tube2_y_pos;
                    snap_ty_q[2] <= tube3_y_pos;
                    ground_q     <= ground_now;
                    any_hit_q    <= 1'b0;
                    first_tube_q <= 2'd0;
                    state_q      <= ST_T0;
                end
                ST_T0, ST_T1: begin
                    // Only the first hitting tube is remembered
                    if (tube_hit && !any_hit_q) begin
                        any_hit_q    <= 1'b1;
                        first_tube_q <= tube_idx;
                    end
                    state_q <= (state_q == ST_T0) ? ST_T1 : ST_T2;
                end
                ST_T2: begin
                    hit_cnt_q <= round_hit ? hit_cnt_d : 3'd0;
                    if (round_hit && confirm) begin
                        state_q <= ST_CRASH;
                        hold_q  <= 8'd0;
                        if (ground_q) begin
                            cause_q <= CAUSE_GROUND;
                            tube_q  <= 2'd0;
                        end else begin
                            cause_q <= CAUSE_TUBE;
                            tube_q  <= any_hit_q ? first_tube_q : 2'd2;
                        end
                    end else begin
                        state_q <= ST_SNAP;
                    end
                end
                ST_CRASH: begin
                    hold_q <= hold_d;
                    if (start && hold_done) begin
                        state_q    <= ST_IDLE;
                        new_game_q <= 1'b1;
                        cause_q    <= CAUSE_NONE;
                        tube_q     <= 2'd0;
                        hit_cnt_q  <= 3'd0;
                        hold_q     <= 8'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign playing     = (state_q == ST_SNAP) || (state_q == ST_T0) ||
                         (state_q == ST_T1)   || (state_q == ST_T2);
    assign game_end    = (state_q == ST_CRASH);
    assign new_game    = new_game_q;
    assign crash_cause = cause_q;
    assign crash_tube  = tube_q;

endmodule

// File: tb/tb_collision_detect.sv
// ----------------------------------------------------------------------------
// tb_collision_detect
// Self-checking bench for collision_detect: a table of single-round vectors
// (bird/tube geometry with the expected crash outcome) driven through a
// scoreboard queue, plus hand-written sequences for reset, snapshot, restart
// holdoff and multi-round hit confirmation.
// ----------------------------------------------------------------------------
module tb_collision_detect;
    import flappy_pkg::*;

    // Single-round vector: inputs plus the expected state after the round
    typedef struct {
        string      name;
        logic [9:0] by;
        logic [9:0] t1x;
        logic [9:0] t1y;
        logic [9:0] t2x;
        logic [9:0] t2y;
        logic [9:0] t3x;
        logic [9:0] t3y;
        logic       expEnd;
        logic [1:0] expCause;
        logic [1:0] expTube;
    } vec_t;

    typedef struct {
        string      name;
        logic       gameEnd;
        logic       playing;
        logic [1:0] cause;
        logic [1:0] tube;
    } exp_t;

    logic       clk10;
    logic       clr;
    logic       start;
    logic [9:0] birdY;
    logic [9:0] t1x, t2x, t3x, t1y, t2y, t3y;
    logic       playing, gameEnd, newGame;
    logic [1:0] crashCause, crashTube;

    logic       clr2;
    logic       start2;
    logic [9:0] birdY2;
    logic [9:0] u1x, u2x, u3x, u1y, u2y, u3y;
    logic       playing2, gameEnd2, newGame2;
    logic [1:0] crashCause2, crashTube2;

    int   nChecks = 0;
    int   nFails  = 0;
    vec_t vecs[$];
    exp_t sb[$];

    collision_detect dut (
        .clk10       (clk10),
        .clr         (clr),
        .start       (start),
        .bird_y_pos  (birdY),
        .tube1_x_pos (t1x),
        .tube2_x_pos (t2x),
        .tube3_x_pos (t3x),
        .tube1_y_pos (t1y),
        .tube2_y_pos (t2y),
        .tube3_y_pos (t3y),
        .playing     (playing),
        .game_end    (gameEnd),
        .new_game    (newGame),
        .crash_cause (crashCause),
        .crash_tube  (crashTube)
    );

    collision_detect #(
        .HIT_CONFIRM  (2),
        .RESTART_HOLD (3)
    ) dut2 (
        .clk10       (clk10),
        .clr         (clr2),
        .start       (start2),
        .bird_y_pos  (birdY2),
        .tube1_x_pos (u1x),
        .tube2_x_pos (u2x),
        .tube3_x_pos (u3x),
        .tube1_y_pos (u1y),
        .tube2_y_pos (u2y),
        .tube3_y_pos (u3y),
        .playing     (playing2),
        .game_end    (gameEnd2),
        .new_game    (newGame2),
        .crash_cause (crashCause2),
        .crash_tube  (crashTube2)
    );

    initial clk10 = 1'b0;
    always #5 clk10 = ~clk10;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk10);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reset, load geometry, queue the expected outcome and press start once
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        clr = 1'b1;
        tick();
        clr   = 1'b0;
        birdY = v.by;
        t1x = v.t1x; t1y = v.t1y;
        t2x = v.t2x; t2y = v.t2y;
        t3x = v.t3x; t3y = v.t3y;
        e.name    = v.name;
        e.gameEnd = v.expEnd;
        e.playing = !v.expEnd;
        e.cause   = v.expCause;
        e.tube    = v.expTube;
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic setGeom(input logic [9:0] by, input logic [9:0] ax, input logic [9:0] ay);
        birdY = by;
        t1x = ax;  t1y = ay;
        t2x = 804; t2y = 240;
        t3x = 804; t3y = 240;
    endtask

    task automatic setGeom2(input logic [9:0] by);
        birdY2 = by;
        u1x = 230; u1y = 240;
        u2x = 804; u2y = 240;
        u3x = 804; u3y = 240;
    endtask

    initial begin
        exp_t e;
        int   bad;
        int   pulses;
        int   pulseAt;
        int   geAt20;
        int   geAt21;

        clr = 1'b1; start = 1'b0;
        setGeom(230, 804, 240);
        clr2 = 1'b1; start2 = 1'b0;
        setGeom2(230);

        // name, by, t1x,t1y, t2x,t2y, t3x,t3y, end, cause, tube
        vecs.push_back('{"gap_center",    230, 230,240, 804,240, 804,240, 1'b0, 2'd0, 2'd0});
        vecs.push_back('{"gap_top_edge",  180, 230,240, 804,240, 804,240, 1'b0, 2'd0, 2'd0});
        vecs.push_back('{"gap_top_out",   179, 230,240, 804,240, 804,240, 1'b1, 2'd1, 2'd0});
        vecs.push_back('{"gap_bot_edge",  280, 230,240, 804,240, 804,240, 1'b0, 2'd0, 2'd0});
        vecs.push_back('{"gap_bot_out",   281, 230,240, 804,240, 804,240, 1'b1, 2'd1, 2'd0});
        vecs.push_back('{"col_left_out",  150, 200,240, 804,240, 804,240, 1'b0, 2'd0, 2'd0});
        vecs.push_back('{"col_right_out", 150, 280,240, 804,240, 804,240, 1'b0, 2'd0, 2'd0});
        vecs.push_back('{"col_left_in",   150, 201,240, 804,240, 804,240, 1'b1, 2'd1, 2'd0});
        vecs.push_back('{"col_right_in",  150, 279,240, 804,240, 804,240, 1'b1, 2'd1, 2'd0});
        vecs.push_back('{"tube2_hit",     150, 804,240, 210,240, 804,240, 1'b1, 2'd1, 2'd1});
        vecs.push_back('{"ground_prio",   425, 804,240, 804,240, 230,240, 1'b1, 2'd2, 2'd0});
        vecs.push_back('{"ground_edge",   420, 804,240, 804,240, 804,240, 1'b0, 2'd0, 2'd0});
        vecs.push_back('{"ground_over",   421, 804,240, 804,240, 804,240, 1'b1, 2'd2, 2'd0});
        vecs.push_back('{"lowest_index",  150, 804,240, 230,240, 250,240, 1'b1, 2'd1, 2'd1});
        vecs.push_back('{"tube3_hit",     281, 804,240, 804,240, 260,240, 1'b1, 2'd1, 2'd2});

        // Reset values
        tick(); tick();
        clr = 1'b0;
        checkOutput("rst_playing",  int'(playing),    0);
        checkOutput("rst_game_end", int'(gameEnd),    0);
        checkOutput("rst_new_game", int'(newGame),    0);
        checkOutput("rst_cause",    int'(crashCause), 0);
        checkOutput("rst_tube",     int'(crashTube),  0);

        // Table vectors: the round ends 4 edges after the start edge
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            repeat (4) tick();
            if (sb.size() == 0) begin
                checkOutput("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_game_end"}, int'(gameEnd),    int'(e.gameEnd));
                checkOutput({e.name, "_playing"},  int'(playing),    int'(e.playing));
                checkOutput({e.name, "_cause"},    int'(crashCause), int'(e.cause));
                checkOutput({e.name, "_tube"},     int'(crashTube),  int'(e.tube));
            end
        end

        // clr held 2 cycles mid-round (in T1), with start asserted too
        clr = 1'b1; tick(); clr = 1'b0;
        setGeom(230, 230, 240);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        checkOutput("midround_in_t1_playing", int'(playing), 1);
        clr = 1'b1; start = 1'b1;
        tick(); tick();
        clr = 1'b0; start = 1'b0;
        checkOutput("midround_clr_playing",  int'(playing),    0);
        checkOutput("midround_clr_game_end", int'(gameEnd),    0);
        checkOutput("midround_clr_cause",    int'(crashCause), 0);
        checkOutput("midround_clr_new_game", int'(newGame),    0);
        tick();
        checkOutput("midround_stays_idle",   int'(playing),    0);

        // Safe flight through the gap for 200 cycles
        setGeom(230, 230, 240);
        start = 1'b1; tick(); start = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!playing || gameEnd) bad++;
            tick();
        end
        checkOutput("safe_200_bad_cycles", bad, 0);

        // Snapshot: inputs changed after SNAP do not affect the round
        clr = 1'b1; tick(); clr = 1'b0;
        setGeom(150, 230, 240);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        setGeom(230, 230, 240);
        repeat (3) tick();
        checkOutput("snap_hit_kept_game_end", int'(gameEnd), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        setGeom(230, 230, 240);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        setGeom(150, 230, 240);
        repeat (3) tick();
        checkOutput("snap_clear_kept_game_end", int'(gameEnd), 0);

        // Restart with start held from the crash: CRASH spans hold counts
        // 0..20, so the pulse appears 21 edges after game_end rises
        clr = 1'b1; tick(); clr = 1'b0;
        setGeom(150, 804, 240);
        t2x = 210;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        checkOutput("latency_before_crash", int'(gameEnd), 0);
        tick();
        checkOutput("latency_crash", int'(gameEnd), 1);
        setGeom(230, 804, 240);
        start  = 1'b1;
        pulses = 0; pulseAt = -1; geAt20 = -1; geAt21 = -1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (newGame) begin
                pulses++;
                pulseAt = i;
            end
            if (i == 20) geAt20 = int'(gameEnd);
            if (i == 21) geAt21 = int'(gameEnd);
        end
        start = 1'b0;
        checkOutput("restart_pulse_count",   pulses,  1);
        checkOutput("restart_pulse_cycle",   pulseAt, 21);
        checkOutput("restart_hold_game_end", geAt20,  1);
        checkOutput("restart_game_end_drop", geAt21,  0);
        checkOutput("restart_playing_again", int'(playing), 1);

        // clr and start together in CRASH after the holdoff: no pulse
        clr = 1'b1; tick(); clr = 1'b0;
        setGeom(150, 230, 240);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        repeat (25) tick();
        checkOutput("crash_waits_game_end", int'(gameEnd), 1);
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        checkOutput("clr_start_new_game", int'(newGame),    0);
        checkOutput("clr_start_game_end", int'(gameEnd),    0);
        checkOutput("clr_start_cause",    int'(crashCause), 0);

        // HIT_CONFIRM=2: a single hit round is forgiven
        tick();
        clr2 = 1'b0;
        setGeom2(150);
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick();
        setGeom2(230);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gameEnd2) bad++;
        end
        checkOutput("confirm2_single_round", bad, 0);

        // HIT_CONFIRM=2: two consecutive hit rounds crash at the 8th edge
        clr2 = 1'b1; tick(); clr2 = 1'b0;
        setGeom2(150);
        start2 = 1'b1; tick(); start2 = 1'b0;
        repeat (7) tick();
        checkOutput("confirm2_round1_end", int'(gameEnd2), 0);
        tick();
        checkOutput("confirm2_crash",      int'(gameEnd2),    1);
        checkOutput("confirm2_cause",      int'(crashCause2), 1);
        checkOutput("confirm2_tube",       int'(crashTube2),  0);

        // RESTART_HOLD=3 on the second instance
        start2 = 1'b1;
        repeat (3) tick();
        checkOutput("hold3_no_pulse_yet", int'(newGame2), 0);
        tick();
        checkOutput("hold3_pulse",        int'(newGame2), 1);
        start2 = 1'b0;
        tick();
        checkOutput("hold3_pulse_width",  int'(newGame2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
